// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle between an external controller (master) and the register-file peripheral (slave).
// CIPO_oe tells the pad logic when the peripheral is actually driving CIPO.
interface spi_regfile_peripheral_if;
   logic sCLK;
   logic nCS;
   logic COPI;
   logic CIPO;
   logic CIPO_oe;

   modport master (output sCLK, output nCS, output COPI, input CIPO, input CIPO_oe);
   modport slave  (input sCLK, input nCS, input COPI, output CIPO, output CIPO_oe);
endinterface

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral exposing a small bank of control registers.
// Frame is rw, address, data (MSB first); all SPI pins are oversampled on clk.
module spi_regfile_peripheral #(
   parameter int NUM_REGS    = 5,
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   spi_regfile_peripheral_if.slave      spi,
   output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
   output logic                         wr_strobe,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic                         frame_err,
   input  logic                         err_clr,
   output logic [1:0]                   fsm_state
);

   localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
   localparam int CNT_W     = $clog2(FRAME_LEN) + 1;
   localparam logic [CNT_W-1:0] LEN_C       = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] SAT_C       = CNT_W'(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_ADDR_C = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] LAST_DATA_C = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_END} state_t;

   state_t                   state;
   logic [CNT_W-1:0]         bit_cnt;
   logic                     rw;
   logic [ADDR_W-1:0]        addr;
   logic [DATA_W-1:0]        wr_data;
   logic [DATA_W-1:0]        rd_shift;
   logic                     cipo_q;
   logic                     cipo_oe_q;

   logic [SYNC_STAGES-1:0]   sclk_sync;
   logic [SYNC_STAGES-1:0]   ncs_sync;
   logic [SYNC_STAGES-1:0]   copi_sync;
   logic                     sclk_prev;
   logic                     ncs_prev;

   logic                     sclk_s;
   logic                     ncs_s;
   logic                     copi_s;
   logic                     sclk_rise;
   logic                     sclk_fall;
   logic                     ncs_rise;
   logic                     ncs_fall;
   logic [ADDR_W-1:0]        addr_shifted;
   logic [DATA_W-1:0]        rd_val;
   logic                     wr_hit;

   // One extra flop past the synchroniser gives the edge detector a stable previous sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         ncs_sync  <= '1;
         copi_sync <= '0;
         sclk_prev <= 1'b0;
         ncs_prev  <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sCLK};
         ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.nCS};
         copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.COPI};
         sclk_prev <= sclk_sync[SYNC_STAGES-1];
         ncs_prev  <= ncs_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s       = sclk_sync[SYNC_STAGES-1];
   assign ncs_s        = ncs_sync[SYNC_STAGES-1];
   assign copi_s       = copi_sync[SYNC_STAGES-1];
   assign sclk_rise    = sclk_s & ~sclk_prev;
   assign sclk_fall    = ~sclk_s & sclk_prev;
   assign ncs_rise     = ncs_s & ~ncs_prev;
   assign ncs_fall     = ~ncs_s & ncs_prev;
   assign addr_shifted = {addr[ADDR_W-2:0], copi_s};

   // Out-of-range addresses read as zero and never hit on write.
   always_comb begin
      rd_val = '0;
      wr_hit = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr_shifted == ADDR_W'(i)) rd_val = regs_flat[i*DATA_W +: DATA_W];
         if (addr == ADDR_W'(i)) wr_hit = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         rw        <= 1'b0;
         addr      <= '0;
         wr_data   <= '0;
         rd_shift  <= '0;
         cipo_q    <= 1'b0;
         cipo_oe_q <= 1'b0;
         regs_flat <= '0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         frame_err <= 1'b0;
      end else begin
         wr_strobe <= 1'b0;
         if (ncs_rise) begin
            // Frame end wins over any sCLK edge seen in the same cycle.
            if (state != S_IDLE) begin
               if (bit_cnt == LEN_C) begin
                  if (rw && wr_hit) begin
                     for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr == ADDR_W'(i)) regs_flat[i*DATA_W +: DATA_W] <= wr_data;
                     end
                     wr_addr   <= addr;
                     wr_strobe <= 1'b1;
                  end
               end else begin
                  frame_err <= 1'b1;
               end
            end
            state     <= S_IDLE;
            cipo_q    <= 1'b0;
            cipo_oe_q <= 1'b0;
         end else if (ncs_fall) begin
            state    <= S_ADDR;
            bit_cnt  <= '0;
            rw       <= 1'b0;
            addr     <= '0;
            wr_data  <= '0;
            rd_shift <= '0;
         end else if (state != S_IDLE) begin
            if (sclk_rise) begin
               if (bit_cnt != SAT_C) bit_cnt <= bit_cnt + 1'b1;
               case (state)
                  S_ADDR: begin
                     if (bit_cnt == '0) begin
                        rw <= copi_s;
                     end else begin
                        addr <= addr_shifted;
                        if (bit_cnt == LAST_ADDR_C) begin
                           state <= S_DATA;
                           if (!rw) rd_shift <= rd_val;
                        end
                     end
                  end
                  S_DATA: begin
                     if (rw) wr_data <= {wr_data[DATA_W-2:0], copi_s};
                     if (bit_cnt == LAST_DATA_C) state <= S_END;
                  end
                  default: ;
               endcase
            end else if (sclk_fall && state == S_DATA && !rw) begin
               cipo_q    <= rd_shift[DATA_W-1];
               rd_shift  <= {rd_shift[DATA_W-2:0], 1'b0};
               cipo_oe_q <= 1'b1;
            end
         end
         if (err_clr) frame_err <= 1'b0;
      end
   end

   assign spi.CIPO    = cipo_q;
   assign spi.CIPO_oe = cipo_oe_q;
   assign fsm_state   = state;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral: bit-banged SPI mode-0 frames with
// hand-computed register, strobe, read-back and error expectations.
module tb_spi_regfile_peripheral;

   localparam int HALF = 8;

   logic        clk;
   logic        rst_n;
   logic        err_clr;
   logic [39:0] regs_flat;
   logic        wr_strobe;
   logic [6:0]  wr_addr;
   logic        frame_err;
   logic [1:0]  fsm_state;

   int checks = 0;
   int failures = 0;
   int strobe_cycles = 0;
   int strobe_pulses = 0;
   logic strobe_q = 1'b0;

   spi_regfile_peripheral_if spi ();

   spi_regfile_peripheral #(.NUM_REGS(5), .ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi       (spi),
      .regs_flat (regs_flat),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .frame_err (frame_err),
      .err_clr   (err_clr),
      .fsm_state (fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_strobe) strobe_cycles++;
      if (wr_strobe && !strobe_q) strobe_pulses++;
      strobe_q = wr_strobe;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives nbits of {rw, addr, data}; bits past 16 are zero. Collects CIPO on data-phase rises.
   task automatic spi_frame(input logic rw, input logic [6:0] a, input logic [7:0] d,
                            input int nbits, input bit close,
                            output logic [7:0] rd, output int oe_errs);
      logic [15:0] fr;
      logic        exp_oe;
      fr = {rw, a, d};
      rd = '0;
      oe_errs = 0;
      spi.nCS = 1'b0;
      wait_clks(HALF);
      for (int i = 0; i < nbits; i++) begin
         spi.COPI = (i < 16) ? fr[15-i] : 1'b0;
         wait_clks(HALF);
         spi.sCLK = 1'b1;
         if (i >= 8 && i < 16) rd = {rd[6:0], spi.CIPO};
         exp_oe = (!rw && i >= 8);
         if (spi.CIPO_oe !== exp_oe) oe_errs++;
         wait_clks(HALF);
         spi.sCLK = 1'b0;
      end
      wait_clks(HALF);
      spi.COPI = 1'b0;
      if (close) spi.nCS = 1'b1;
   endtask

   task automatic test_reset();
      checks++; if (regs_flat !== 40'h0) begin failures++; $display("FAIL reset_regs got=%h exp=%h", regs_flat, 40'h0); end
      checks++; if (spi.CIPO !== 1'b0 || spi.CIPO_oe !== 1'b0) begin failures++; $display("FAIL reset_cipo got=%b/%b exp=0/0", spi.CIPO, spi.CIPO_oe); end
      checks++; if (wr_strobe !== 1'b0 || wr_addr !== 7'h0) begin failures++; $display("FAIL reset_wr got=%b/%h exp=0/00", wr_strobe, wr_addr); end
      checks++; if (frame_err !== 1'b0 || fsm_state !== 2'd0) begin failures++; $display("FAIL reset_err_state got=%b/%0d exp=0/0", frame_err, fsm_state); end
   endtask

   task automatic test_write();
      logic [7:0] rd;
      int oe_errs;
      int p0;
      p0 = strobe_pulses;
      spi_frame(1'b1, 7'h02, 8'hA5, 16, 1'b1, rd, oe_errs);
      checks++; if (oe_errs !== 0) begin failures++; $display("FAIL write_oe got=%0d exp=0", oe_errs); end
      wait_clks(2);
      checks++; if (regs_flat !== 40'h0) begin failures++; $display("FAIL write_early got=%h exp=%h", regs_flat, 40'h0); end
      wait_clks(1);
      checks++; if (regs_flat !== 40'h00_00_A5_00_00) begin failures++; $display("FAIL write_regs got=%h exp=%h", regs_flat, 40'h00_00_A5_00_00); end
      checks++; if (wr_strobe !== 1'b1 || wr_addr !== 7'h02) begin failures++; $display("FAIL write_strobe got=%b/%h exp=1/02", wr_strobe, wr_addr); end
      wait_clks(1);
      checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL write_strobe_width got=%b exp=0", wr_strobe); end
      wait_clks(4);
      checks++; if (strobe_pulses - p0 !== 1) begin failures++; $display("FAIL write_pulses got=%0d exp=1", strobe_pulses - p0); end
   endtask

   task automatic test_read();
      logic [7:0] rd;
      int oe_errs;
      int c0;
      spi_frame(1'b1, 7'h04, 8'h3C, 16, 1'b1, rd, oe_errs);
      wait_clks(8);
      c0 = strobe_cycles;
      spi_frame(1'b0, 7'h04, 8'h00, 16, 1'b1, rd, oe_errs);
      checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL read_data got=%h exp=%h", rd, 8'h3C); end
      checks++; if (oe_errs !== 0) begin failures++; $display("FAIL read_oe_window got=%0d exp=0", oe_errs); end
      wait_clks(4);
      checks++; if (spi.CIPO_oe !== 1'b0 || spi.CIPO !== 1'b0) begin failures++; $display("FAIL read_release got=%b/%b exp=0/0", spi.CIPO_oe, spi.CIPO); end
      checks++; if (regs_flat !== 40'h3C_00_A5_00_00) begin failures++; $display("FAIL read_regs got=%h exp=%h", regs_flat, 40'h3C_00_A5_00_00); end
      checks++; if (strobe_cycles - c0 !== 0) begin failures++; $display("FAIL read_strobe got=%0d exp=0", strobe_cycles - c0); end
      spi_frame(1'b0, 7'h02, 8'h00, 16, 1'b1, rd, oe_errs);
      checks++; if (rd !== 8'hA5) begin failures++; $display("FAIL read_reg2 got=%h exp=%h", rd, 8'hA5); end
      wait_clks(8);
   endtask

   task automatic test_out_of_range();
      logic [7:0] rd;
      int oe_errs;
      int c0;
      c0 = strobe_cycles;
      spi_frame(1'b1, 7'h10, 8'hFF, 16, 1'b1, rd, oe_errs);
      wait_clks(8);
      checks++; if (regs_flat !== 40'h3C_00_A5_00_00) begin failures++; $display("FAIL oor_regs got=%h exp=%h", regs_flat, 40'h3C_00_A5_00_00); end
      checks++; if (strobe_cycles - c0 !== 0) begin failures++; $display("FAIL oor_strobe got=%0d exp=0", strobe_cycles - c0); end
      checks++; if (frame_err !== 1'b0 || wr_addr !== 7'h04) begin failures++; $display("FAIL oor_err_addr got=%b/%h exp=0/04", frame_err, wr_addr); end
      spi_frame(1'b0, 7'h10, 8'h00, 16, 1'b1, rd, oe_errs);
      checks++; if (rd !== 8'h00) begin failures++; $display("FAIL oor_read got=%h exp=00", rd); end
      wait_clks(8);
   endtask

   task automatic test_frame_err();
      logic [7:0] rd;
      int oe_errs;
      int c0;
      c0 = strobe_cycles;
      spi_frame(1'b1, 7'h00, 8'h77, 12, 1'b1, rd, oe_errs);
      wait_clks(6);
      checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL err_short got=%b exp=1", frame_err); end
      spi_frame(1'b1, 7'h00, 8'h77, 17, 1'b1, rd, oe_errs);
      wait_clks(6);
      checks++; if (frame_err !== 1'b1 || regs_flat !== 40'h3C_00_A5_00_00) begin failures++; $display("FAIL err_long got=%b/%h exp=1/%h", frame_err, regs_flat, 40'h3C_00_A5_00_00); end
      checks++; if (strobe_cycles - c0 !== 0) begin failures++; $display("FAIL err_strobe got=%0d exp=0", strobe_cycles - c0); end
      err_clr = 1'b1;
      wait_clks(1);
      err_clr = 1'b0;
      wait_clks(1);
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL err_clr got=%b exp=0", frame_err); end
      // Clear held across the cycle the error would be set.
      spi_frame(1'b1, 7'h00, 8'h77, 5, 1'b0, rd, oe_errs);
      err_clr = 1'b1;
      spi.nCS = 1'b1;
      wait_clks(6);
      err_clr = 1'b0;
      wait_clks(2);
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL err_clr_priority got=%b exp=0", frame_err); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] rd;
      int oe_errs;
      int c0;
      spi_frame(1'b1, 7'h00, 8'h00, 3, 1'b1, rd, oe_errs);
      wait_clks(6);
      checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL mid_pre_err got=%b exp=1", frame_err); end
      c0 = strobe_cycles;
      spi_frame(1'b1, 7'h01, 8'h55, 9, 1'b0, rd, oe_errs);
      rst_n = 1'b0;
      wait_clks(1);
      spi.nCS = 1'b1;
      wait_clks(4);
      rst_n = 1'b1;
      wait_clks(4);
      checks++; if (regs_flat !== 40'h0 || wr_addr !== 7'h0) begin failures++; $display("FAIL mid_regs got=%h/%h exp=0/0", regs_flat, wr_addr); end
      checks++; if (frame_err !== 1'b0 || fsm_state !== 2'd0 || spi.CIPO_oe !== 1'b0) begin failures++; $display("FAIL mid_state got=%b/%0d/%b exp=0/0/0", frame_err, fsm_state, spi.CIPO_oe); end
      checks++; if (strobe_cycles - c0 !== 0) begin failures++; $display("FAIL mid_strobe got=%0d exp=0", strobe_cycles - c0); end
      spi_frame(1'b1, 7'h01, 8'h55, 16, 1'b1, rd, oe_errs);
      wait_clks(3);
      checks++; if (regs_flat !== 40'h00_00_00_55_00 || wr_strobe !== 1'b1 || wr_addr !== 7'h01) begin failures++; $display("FAIL mid_recover got=%h/%b/%h exp=%h/1/01", regs_flat, wr_strobe, wr_addr, 40'h00_00_00_55_00); end
      wait_clks(6);
   endtask

   task automatic test_back_to_back();
      logic [7:0] rd;
      int oe_errs;
      int p0;
      int c0;
      p0 = strobe_pulses;
      c0 = strobe_cycles;
      spi_frame(1'b1, 7'h00, 8'h11, 16, 1'b1, rd, oe_errs);
      wait_clks(4 * HALF - HALF);
      spi_frame(1'b1, 7'h01, 8'h22, 16, 1'b1, rd, oe_errs);
      wait_clks(6);
      checks++; if (regs_flat !== 40'h00_00_00_22_11) begin failures++; $display("FAIL b2b_regs got=%h exp=%h", regs_flat, 40'h00_00_00_22_11); end
      checks++; if (strobe_pulses - p0 !== 2 || strobe_cycles - c0 !== 2) begin failures++; $display("FAIL b2b_strobes got=%0d/%0d exp=2/2", strobe_pulses - p0, strobe_cycles - c0); end
      checks++; if (wr_addr !== 7'h01 || frame_err !== 1'b0) begin failures++; $display("FAIL b2b_addr_err got=%h/%b exp=01/0", wr_addr, frame_err); end
   endtask

   initial begin
      rst_n    = 1'b0;
      err_clr  = 1'b0;
      spi.sCLK = 1'b0;
      spi.nCS  = 1'b1;
      spi.COPI = 1'b0;
      wait_clks(5);
      rst_n = 1'b1;
      wait_clks(4);
      test_reset();
      test_write();
      test_read();
      test_out_of_range();
      test_frame_err();
      test_reset_mid_frame();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
